psk_phase_gen: RTL

//  Parametrised M-PSK phase generator: NCO phase accumulator plus symbol-driven phase offset.

---
 rtl/psk_phase_gen.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/psk_phase_gen.sv
// rtl/psk_phase_gen.sv - M-PSK phase generator: NCO accumulator plus symbol phase offset
// Optional dither: define PSK_PHASE_GEN_DITHER_EN to add 16-bit LFSR dither below the output LSB.
module psk_phase_gen #(
  parameter int ACC_WIDTH       = 24,
  parameter int DATA_WIDTH      = 8,
  parameter int BITS_PER_SYM    = 1,
  parameter int SAMPLES_PER_SYM = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [ACC_WIDTH-1:0]    freq_word,
  input  logic [BITS_PER_SYM-1:0] sym_data,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  output logic [DATA_WIDTH-1:0]   phase,
  output logic                    phase_valid,
  output logic                    sym_strobe,
  output logic                    underrun
);

  localparam int CNT_W = $clog2(SAMPLES_PER_SYM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_SYM - 1);
  localparam int SYM_SHIFT = ACC_WIDTH - BITS_PER_SYM;
  localparam int TRUNC_SHIFT = ACC_WIDTH - DATA_WIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [BITS_PER_SYM-1:0] sym_cur_q, sym_cur_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BITS_PER_SYM-1:0] hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0]   phase_q, phase_d;
  logic                    phase_valid_q, phase_valid_d;
  logic                    sym_strobe_q, sym_strobe_d;
  logic                    underrun_q, underrun_d;

  logic                    boundary;
  logic                    take;
  logic                    accept;
  logic [BITS_PER_SYM-1:0] sym_sel;
  logic [ACC_WIDTH-1:0]    off;
  logic [ACC_WIDTH-1:0]    sum;

`ifdef PSK_PHASE_GEN_DITHER_EN
  localparam logic [ACC_WIDTH-1:0] DITH_MASK = (ACC_WIDTH'(1) << TRUNC_SHIFT) - ACC_WIDTH'(1);

  logic [15:0]          lfsr_q, lfsr_d;
  logic [ACC_WIDTH-1:0] dith;

  // Fibonacci LFSR (taps 16,14,13,11) stepping once per sample strike
  always_comb begin
    lfsr_d = lfsr_q;
    if (enable) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // LFSR register, reseeded on reset so the dither sequence is repeatable
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Only the bits that truncation would discard receive dither
  always_comb begin
    dith = ACC_WIDTH'(lfsr_q) & DITH_MASK;
    sum  = acc_q + off + dith;
  end
`else
  // Plain truncation path
  always_comb begin
    sum = acc_q + off;
  end
`endif

  // Symbol-boundary decode and the fill-and-drain holding register handshake
  always_comb begin
    boundary  = (state_q == RUN) && (cnt_q == CNT_LAST);
    take      = enable && hold_full_q && ((state_q == IDLE) || boundary);
    sym_ready = ~hold_full_q | take;
    accept    = sym_valid && sym_ready;
    // Leaving IDLE, the held symbol drives this very sample so the symbol spans SAMPLES_PER_SYM outputs
    sym_sel   = ((state_q == IDLE) && take) ? hold_q : sym_cur_q;
    off       = ACC_WIDTH'(sym_sel) << SYM_SHIFT;
  end

  // Next-state: accumulator, symbol FSM, holding register and output pulses
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    sym_cur_d     = sym_cur_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    phase_d       = phase_q;
    phase_valid_d = enable;
    sym_strobe_d  = 1'b0;
    underrun_d    = 1'b0;

    // Intake is a pure handshake; it does not wait for a sample strike
    if (accept) begin
      hold_d      = sym_data;
      hold_full_d = 1'b1;
    end else if (take) begin
      hold_full_d = 1'b0;
    end

    if (enable) begin
      acc_d   = acc_q + freq_word;
      phase_d = DATA_WIDTH'(sum >> TRUNC_SHIFT);
      case (state_q)
        IDLE: begin
          if (hold_full_q) begin
            sym_cur_d    = hold_q;
            cnt_d        = CNT_W'(1);
            state_d      = RUN;
            sym_strobe_d = 1'b1;
          end
        end
        RUN: begin
          // cnt is 0 only on the first sample after a boundary hand-over
          sym_strobe_d = (cnt_q == '0);
          if (boundary) begin
            cnt_d = '0;
            if (hold_full_q) begin
              sym_cur_d = hold_q;
            end else begin
              sym_cur_d  = '0;
              underrun_d = 1'b1;
              state_d    = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      sym_cur_q     <= '0;
      cnt_q         <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      sym_strobe_q  <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      sym_cur_q     <= sym_cur_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      sym_strobe_q  <= sym_strobe_d;
      underrun_q    <= underrun_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign sym_strobe  = sym_strobe_q;
  assign underrun    = underrun_q;

endmodule
